// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file: byte size, address-width
// computation and the byte-enable merge used by both storage and bypass.
package regfile_pkg;

   localparam int BYTE   = 8;
   localparam int MAX_W  = 1024;
   localparam int MAX_BE = MAX_W / BYTE;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Words narrower than MAX_W are zero-extended by the caller and sliced back.
   function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0]  old_w,
                                                   input logic [MAX_W-1:0]  new_w,
                                                   input logic [MAX_BE-1:0] be);
      logic [MAX_W-1:0] res;
      res = old_w;
      for (int k = 0; k < MAX_BE; k++) begin
         if (be[k]) res[k*BYTE +: BYTE] = new_w[k*BYTE +: BYTE];
      end
      return res;
   endfunction

endpackage

// File: rtl/register_file_be.sv
// One storage word with per-byte write enable and synchronous active-low clear.
module register_be
   import regfile_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [WIDTH/BYTE-1:0] be,
   input  logic [WIDTH-1:0]      d,
   output logic [WIDTH-1:0]      q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [MAX_W-1:0] merged;
   logic             unused_merge;

   always_comb begin
      merged = byte_merge(MAX_W'(q_q), MAX_W'(d), MAX_BE'(be));
      q_d    = q_q;
      if (en) q_d = merged[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q            = q_q;
   assign unused_merge = ^merged;

endmodule

// File: rtl/register_file.sv
// Multi-port register file: one byte-enabled write port, two read ports that
// are either combinational or registered, optional write bypass and zero entry.
module register_file
   import regfile_pkg::*;
#(
   parameter  int WIDTH    = 32,
   parameter  int DEPTH    = 32,
   parameter  int ZERO_REG = 1,
   parameter  int REG_READ = 0,
   parameter  int BYPASS   = 1,
   localparam int AW       = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [WIDTH/BYTE-1:0] wbe,
   input  logic                  re_a,
   input  logic                  re_b,
   input  logic [AW-1:0]         raddr_a,
   input  logic [AW-1:0]         raddr_b,
   output logic [WIDTH-1:0]      rdata_a,
   output logic [WIDTH-1:0]      rdata_b
);

   logic [WIDTH-1:0] entry [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      if (ZERO_REG != 0 && i == 0) begin : g_zero
         assign entry[i] = '0;
      end else begin : g_reg
         register_be #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (we && (waddr == AW'(i))),
            .be    (wbe),
            .d     (wdata),
            .q     (entry[i])
         );
      end
   end

   // Both read ports share one description, indexed 0 = a, 1 = b.
   logic [AW-1:0]    raddr     [2];
   logic             re        [2];
   logic [MAX_W-1:0] merged    [2];
   logic [WIDTH-1:0] rv        [2];
   logic [WIDTH-1:0] rdata_d   [2];
   logic [WIDTH-1:0] rdata_q   [2];
   logic             unused_merge;

   assign raddr[0] = raddr_a;
   assign raddr[1] = raddr_b;
   assign re[0]    = re_a;
   assign re[1]    = re_b;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         merged[p] = byte_merge(MAX_W'(entry[raddr[p]]), MAX_W'(wdata), MAX_BE'(wbe));
         rv[p]     = entry[raddr[p]];
         if (BYPASS != 0 && we && raddr[p] == waddr) rv[p] = merged[p][WIDTH-1:0];
         // The zero entry must win over the bypass path.
         if (ZERO_REG != 0 && raddr[p] == '0) rv[p] = '0;
         rdata_d[p] = re[p] ? rv[p] : rdata_q[p];
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (!reset) rdata_q[p] <= '0;
         else        rdata_q[p] <= rdata_d[p];
      end
   end

   assign rdata_a      = (REG_READ != 0) ? rdata_q[0] : rv[0];
   assign rdata_b      = (REG_READ != 0) ? rdata_q[1] : rv[1];
   assign unused_merge = ^{merged[0], merged[1]};

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: three configurations driven by shared stimulus and
// checked every cycle against an array-based reference model.
module tb_register_file;

   logic        clk;
   logic        reset;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [3:0]  wbe;
   logic        re_a;
   logic        re_b;
   logic [4:0]  raddr_a;
   logic [4:0]  raddr_b;

   // a: zero entry, combinational, bypass
   // b: no zero entry, registered, bypass
   // c: zero entry, combinational, no bypass
   logic [31:0] a_rdata_a, a_rdata_b;
   logic [31:0] b_rdata_a, b_rdata_b;
   logic [31:0] c_rdata_a, c_rdata_b;

   register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .REG_READ(0), .BYPASS(1)) u_a (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .re_a(re_a), .re_b(re_b), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(a_rdata_a), .rdata_b(a_rdata_b));

   register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0), .REG_READ(1), .BYPASS(1)) u_b (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .re_a(re_a), .re_b(re_b), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(b_rdata_a), .rdata_b(b_rdata_b));

   register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .REG_READ(0), .BYPASS(0)) u_c (
      .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .re_a(re_a), .re_b(re_b), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(c_rdata_a), .rdata_b(c_rdata_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;
   bit chk_en = 1'b0;

   // Reference model: contents with and without a hardwired zero entry,
   // plus the two captured outputs of the registered instance.
   logic [31:0] mem_z [32];
   logic [31:0] mem_n [32];
   logic [31:0] reg_ba, reg_bb;

   function automatic logic [31:0] merge_word(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] be);
      logic [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (o & ~mask) | (n & mask);
   endfunction

   function automatic logic [31:0] exp_rv(input bit zero, input bit byp, input logic [4:0] ra);
      logic [31:0] stored;
      stored = zero ? mem_z[ra] : mem_n[ra];
      if (zero && ra == 5'd0) return 32'h0;
      if (byp && we && ra == waddr) return merge_word(stored, wdata, wbe);
      return stored;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%h want=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called just after a falling edge with inputs already applied.
   task automatic tick();
      logic [31:0] nxt_a, nxt_b, wz, wn;
      #1;
      if (chk_en) begin
         check("a_rdata_a", a_rdata_a, exp_rv(1'b1, 1'b1, raddr_a));
         check("a_rdata_b", a_rdata_b, exp_rv(1'b1, 1'b1, raddr_b));
         check("c_rdata_a", c_rdata_a, exp_rv(1'b1, 1'b0, raddr_a));
         check("c_rdata_b", c_rdata_b, exp_rv(1'b1, 1'b0, raddr_b));
         check("b_rdata_a", b_rdata_a, reg_ba);
         check("b_rdata_b", b_rdata_b, reg_bb);
      end
      nxt_a = re_a ? exp_rv(1'b0, 1'b1, raddr_a) : reg_ba;
      nxt_b = re_b ? exp_rv(1'b0, 1'b1, raddr_b) : reg_bb;
      wz    = merge_word(mem_z[waddr], wdata, wbe);
      wn    = merge_word(mem_n[waddr], wdata, wbe);
      @(posedge clk);
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            mem_z[i] = 32'h0;
            mem_n[i] = 32'h0;
         end
         reg_ba = 32'h0;
         reg_bb = 32'h0;
      end else begin
         reg_ba = nxt_a;
         reg_bb = nxt_b;
         if (we) begin
            if (waddr != 5'd0) mem_z[waddr] = wz;
            mem_n[waddr] = wn;
         end
      end
      @(negedge clk);
   endtask

   task automatic set_write(input logic w, input logic [4:0] ad, input logic [31:0] d,
                            input logic [3:0] be);
      we    = w;
      waddr = ad;
      wdata = d;
      wbe   = be;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem_z[i] = 32'h0;
         mem_n[i] = 32'h0;
      end
      reg_ba  = 32'h0;
      reg_bb  = 32'h0;
      reset   = 1'b0;
      set_write(1'b0, 5'd0, 32'h0, 4'h0);
      re_a    = 1'b0;
      re_b    = 1'b0;
      raddr_a = 5'd0;
      raddr_b = 5'd0;

      @(negedge clk);
      tick();
      tick();
      reset  = 1'b1;
      chk_en = 1'b1;

      // Registered outputs are zero straight out of reset; every entry reads zero.
      #1;
      check("lit_b_rst_a", b_rdata_a, 32'h0);
      check("lit_b_rst_b", b_rdata_b, 32'h0);
      re_a = 1'b1;
      re_b = 1'b1;
      for (int i = 0; i < 32; i++) begin
         raddr_a = 5'(i);
         raddr_b = 5'(31 - i);
         tick();
      end

      // Partial-byte write on top of a full write.
      set_write(1'b1, 5'd5, 32'hDEADBEEF, 4'hF);
      tick();
      set_write(1'b1, 5'd5, 32'h00001234, 4'b0011);
      re_a = 1'b0;
      re_b = 1'b0;
      tick();
      set_write(1'b0, 5'd0, 32'h0, 4'h0);
      raddr_a = 5'd5;
      re_a    = 1'b1;
      #1;
      check("lit_a_merge5", a_rdata_a, 32'hDEAD1234);
      tick();
      re_a = 1'b0;
      #1;
      check("lit_b_merge5", b_rdata_a, 32'hDEAD1234);
      tick();

      // Writes to entry 0.
      set_write(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF);
      tick();
      set_write(1'b0, 5'd0, 32'h0, 4'h0);
      raddr_a = 5'd0;
      raddr_b = 5'd0;
      re_a    = 1'b1;
      re_b    = 1'b1;
      #1;
      check("lit_a_zero_a", a_rdata_a, 32'h0);
      check("lit_a_zero_b", a_rdata_b, 32'h0);
      tick();
      #1;
      check("lit_b_nozero_a", b_rdata_a, 32'hFFFFFFFF);
      check("lit_b_nozero_b", b_rdata_b, 32'hFFFFFFFF);
      tick();

      // Same-cycle write and read of entry 7.
      set_write(1'b1, 5'd7, 32'h11111111, 4'hF);
      re_a = 1'b0;
      re_b = 1'b0;
      tick();
      set_write(1'b1, 5'd7, 32'h22222222, 4'hF);
      raddr_a = 5'd7;
      raddr_b = 5'd7;
      re_a    = 1'b1;
      #1;
      check("lit_a_bypass7", a_rdata_a, 32'h22222222);
      check("lit_c_old7", c_rdata_a, 32'h11111111);
      tick();
      set_write(1'b0, 5'd0, 32'h0, 4'h0);
      re_a = 1'b0;
      #1;
      check("lit_c_new7", c_rdata_a, 32'h22222222);
      check("lit_b_bypass7", b_rdata_a, 32'h22222222);
      tick();

      // Registered port holds while its enable is low.
      set_write(1'b1, 5'd3, 32'hA5A5A5A5, 4'hF);
      tick();
      set_write(1'b0, 5'd0, 32'h0, 4'h0);
      raddr_a = 5'd3;
      re_a    = 1'b1;
      tick();
      re_a    = 1'b0;
      raddr_a = 5'd4;
      #1;
      check("lit_b_hold1", b_rdata_a, 32'hA5A5A5A5);
      tick();
      #1;
      check("lit_b_hold2", b_rdata_a, 32'hA5A5A5A5);
      tick();

      // Reset beats a simultaneous write and capture.
      set_write(1'b1, 5'd9, 32'hCAFEF00D, 4'hF);
      raddr_a = 5'd9;
      re_a    = 1'b1;
      reset   = 1'b0;
      tick();
      reset = 1'b1;
      set_write(1'b0, 5'd0, 32'h0, 4'h0);
      re_a = 1'b0;
      #1;
      check("lit_a_rst9", a_rdata_a, 32'h0);
      check("lit_b_rst9", b_rdata_a, 32'h0);
      tick();

      // Randomized traffic with frequent address collisions.
      for (int n = 0; n < 1500; n++) begin
         reset = ($urandom_range(0, 59) != 0);
         set_write(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom(),
                   4'($urandom_range(0, 15)));
         re_a    = $urandom_range(0, 1) == 1;
         re_b    = $urandom_range(0, 1) == 1;
         raddr_a = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
         raddr_b = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
         if ($urandom_range(0, 15) == 0) raddr_a = 5'd0;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-port register file: the next generation of the team's fixed 32×1 enable register. Holds DEPTH words of WIDTH bits, with one write port carrying byte enables and two independent read ports. Each read port is either combinational or registered, selected by parameter. Sits between a CPU decode stage (read) and writeback (write); entry 0 can be hardwired to zero.

## Interface
- WIDTH, 32: word width in bits; must be a multiple of 8, minimum 8
- DEPTH, 32: number of entries; power of two, minimum 2; AW = log2(DEPTH)
- ZERO_REG, 1: 1 = entry 0 reads as zero and ignores writes
- REG_READ, 0: 0 = combinational read ports; 1 = registered read ports (1-cycle latency)
- BYPASS, 1: 1 = a read of the address being written this cycle returns the new data
- clk  in  1  sole clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- wbe  in  WIDTH/8  byte enables; bit k covers wdata[8k+7:8k]
- re_a, re_b  in  1  read enables (used only when REG_READ=1)
- raddr_a, raddr_b  in  AW  read addresses
- rdata_a, rdata_b  out  WIDTH  read data

## Operation
- Reset (reset=0 at a rising edge): every entry is set to 0, and registered rdata_a/rdata_b are set to 0. Reset overrides a simultaneous write and a simultaneous read capture.
- Write: at a rising edge with reset=1 and we=1, each byte k of entry[waddr] with wbe[k]=1 takes wdata byte k. Bytes with wbe[k]=0 hold their value. A write with we=1 and wbe=0 changes nothing.
- ZERO_REG=1: writes to address 0 are discarded, and reads of address 0 return 0 regardless of bypass.
- Read value (rv) for port p:
  - If BYPASS=1, we=1 and raddr_p==waddr (and the address is not a zero register), rv is the merged word: wdata bytes where wbe is set, stored bytes elsewhere.
  - Otherwise rv = entry[raddr_p].
- REG_READ=0: rdata_p = rv, combinationally. re_p is ignored.
- REG_READ=1:
  - At a rising edge with reset=1 and re_p=1, rdata_p captures rv.
  - With re_p=0, rdata_p holds its previous value.
- Both read ports may address the same entry, and may address the write entry, in the same cycle; no stall, no arbitration.
- No error output. All address values are legal because DEPTH is a power of two.

## Timing
- Write-to-storage: written data is visible via a stored read from the cycle after the write edge.
- BYPASS=0, REG_READ=0: a same-cycle read of waddr returns the old value. The new value appears after the edge.
- BYPASS=1, REG_READ=1: a read enabled in the write cycle captures the new value, so rdata shows it one cycle after the edge, with no stale window.
- Read latency is 0 cycles (REG_READ=0) or 1 cycle (REG_READ=1). Throughput is one read per port and one write per cycle.
- Reset release: the first write may occur at the first edge with reset=1.

## Structure
- Package regfile_pkg:
  - function clog2
  - constant BYTE=8
  - helper function byte_merge(old, new, be), which returns the byte-masked merge and is shared by the storage update and the bypass path.
- Sub-module register_be:
  - One WIDTH-bit register with per-byte enable and synchronous active-low clear.
  - Instantiated DEPTH times in a generate loop, or DEPTH-1 times when ZERO_REG=1.
- Read muxes and the optional output registers stay in the top module.

## Test plan
- Reset, then read all addresses: every entry reads 0. With REG_READ=1, rdata_a/rdata_b are 0 immediately after reset.
- Write addr 5 = 0xDEADBEEF with wbe=4'hF, then write addr 5 = 0x00001234 with wbe=4'b0011: addr 5 reads 0xDEAD1234.
- ZERO_REG=1: write addr 0 = 0xFFFFFFFF, then read addr 0 on both ports: both return 0x00000000. With ZERO_REG=0, both return 0xFFFFFFFF.
- Same-cycle write and read of addr 7 (old value 0x11111111, new 0x22222222, wbe=4'hF):
  - BYPASS=1: rdata = 0x22222222.
  - BYPASS=0, REG_READ=0: rdata = 0x11111111, changing to 0x22222222 after the edge.
- REG_READ=1: capture addr 3 (0xA5A5A5A5) with re_a=1, then drop re_a and change raddr_a to 4: rdata_a holds 0xA5A5A5A5.
- Write addr 9 = 0xCAFEF00D in the same cycle as reset=0: after the edge, addr 9 reads 0 and registered outputs are 0.
